intc_prio_loader: RTL and testbench

Configuration sequencer for the interrupt controller's priority-register port. On a `start_i` pulse it captures a full priority table. It then writes one entry per interrupt line through the controller's `valid`/`ready` register handshake and, optionally, reads every entry back and compares it. It sits between boot/config logic and the interrupt controller, and is the only master of that register port while `busy_o` is high.

---
 rtl/intc_pkg.sv | 29 ++
 rtl/intc_bus_req.sv | 43 ++++
 rtl/intc_prio_loader.sv | 171 +++++++++++++++++
 tb/tb_intc_prio_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt-controller priority loader:
// default widths, access timeout and the one-hot sequencer states.
package intc_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_INTR_WIDTH = 16;
  localparam int DEF_INTR_ADDR  = 4;
  localparam int DEF_TIMEOUT    = 15;

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_WR_REQ = 6'b000010,
    S_WR_GAP = 6'b000100,
    S_RD_REQ = 6'b001000,
    S_RD_GAP = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;

  // A request phase is active (valid held towards the controller).
  function automatic logic is_req(state_t s);
    return (s == S_WR_REQ) || (s == S_RD_REQ);
  endfunction

  // Any state that belongs to a running sequence.
  function automatic logic is_busy(state_t s);
    return (s == S_WR_REQ) || (s == S_WR_GAP) || (s == S_RD_REQ) || (s == S_RD_GAP);
  endfunction

endpackage

// File: rtl/intc_bus_req.sv
// Single-access handshake engine for the controller register port.
// A launch pulse raises valid; it stays up until ready is seen (ack) or
// the wait counter expires (tmo). Both results are one-cycle pulses.
module intc_bus_req
  import intc_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_launch,
  input  logic i_ready,
  output logic o_valid,
  output logic o_ack,
  output logic o_tmo
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic          r_valid;
  logic [CW-1:0] r_cnt;

  assign o_valid = r_valid;
  assign o_ack   = r_valid & i_ready;
  // Expires on the TIMEOUT-th request cycle without ready.
  assign o_tmo   = r_valid & ~i_ready & (r_cnt == CW'(TIMEOUT - 1));

  // Valid flag and wait counter; counter restarts with every new access.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (i_launch) begin
      r_valid <= 1'b1;
      r_cnt   <= '0;
    end else if (o_ack || o_tmo) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/intc_prio_loader.sv
// Priority-table loader: captures a table on start, writes every entry to
// the interrupt controller, optionally reads each back and compares.
// All outputs come straight from flops.
module intc_prio_loader
  import intc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INTR_WIDTH = DEF_INTR_WIDTH,
  parameter int INTR_ADDR  = DEF_INTR_ADDR,
  parameter bit VERIFY     = 1'b1,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [INTR_WIDTH*INTR_ADDR-1:0] prio_table_i,
  output logic [DATA_WIDTH-1:0]           addr_o,
  output logic [DATA_WIDTH-1:0]           wr_data_o,
  output logic                            wr_en_o,
  output logic                            rd_en_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  input  logic [DATA_WIDTH-1:0]           rd_data_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic                            err_timeout_o,
  output logic [INTR_ADDR-1:0]            err_idx_o
);

  state_t                          r_state, w_state_n;
  logic [INTR_WIDTH*INTR_ADDR-1:0] r_tab, w_tab_n;
  logic [INTR_ADDR-1:0]            r_idx, w_idx_n;
  logic                            r_err, w_err_n;
  logic                            r_tmo, w_tmo_n;
  logic [INTR_ADDR-1:0]            r_err_idx, w_err_idx_n;

  logic [DATA_WIDTH-1:0]           r_addr, r_wdata;
  logic                            r_wr_en, r_rd_en, r_busy, r_done;

  logic                            w_last, w_launch, w_ack, w_tmo_p, w_valid;
  logic [INTR_ADDR-1:0]            w_entry, w_entry_n;
  logic [DATA_WIDTH-1:0]           w_entry_ext;

  assign w_entry     = r_tab[r_idx*INTR_ADDR +: INTR_ADDR];
  assign w_entry_n   = w_tab_n[w_idx_n*INTR_ADDR +: INTR_ADDR];
  assign w_entry_ext = DATA_WIDTH'(w_entry);
  assign w_last      = (r_idx == INTR_ADDR'(INTR_WIDTH - 1));
  // A new access starts whenever the sequencer moves into a request state.
  assign w_launch    = is_req(w_state_n) && !is_req(r_state);

  intc_bus_req #(.TIMEOUT(TIMEOUT)) u_bus (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .i_launch (w_launch),
    .i_ready  (ready_i),
    .o_valid  (w_valid),
    .o_ack    (w_ack),
    .o_tmo    (w_tmo_p)
  );

  // Next-state, index, table and error-flag decisions.
  always_comb begin
    w_state_n   = r_state;
    w_tab_n     = r_tab;
    w_idx_n     = r_idx;
    w_err_n     = r_err;
    w_tmo_n     = r_tmo;
    w_err_idx_n = r_err_idx;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_tab_n     = prio_table_i;
          w_idx_n     = '0;
          w_err_n     = 1'b0;
          w_tmo_n     = 1'b0;
          w_err_idx_n = '0;
          w_state_n   = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (w_tmo_p) begin
          w_err_n     = 1'b1;
          w_tmo_n     = 1'b1;
          w_err_idx_n = r_idx;
          w_state_n   = S_DONE;
        end else if (w_ack) begin
          w_state_n = S_WR_GAP;
        end
      end
      S_WR_GAP: begin
        if (w_last) begin
          w_idx_n   = '0;
          w_state_n = VERIFY ? S_RD_REQ : S_DONE;
        end else begin
          w_idx_n   = r_idx + 1'b1;
          w_state_n = S_WR_REQ;
        end
      end
      S_RD_REQ: begin
        if (w_tmo_p) begin
          w_err_n     = 1'b1;
          w_tmo_n     = 1'b1;
          w_err_idx_n = r_idx;
          w_state_n   = S_DONE;
        end else if (w_ack) begin
          w_state_n = S_RD_GAP;
          // Mismatches are recorded but the read-back keeps going.
          if (rd_data_i != w_entry_ext) begin
            w_err_n = 1'b1;
            if (!r_err) w_err_idx_n = r_idx;
          end
        end
      end
      S_RD_GAP: begin
        if (w_last) begin
          w_idx_n   = '0;
          w_state_n = S_DONE;
        end else begin
          w_idx_n   = r_idx + 1'b1;
          w_state_n = S_RD_REQ;
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // State, table, error flags and registered port outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_tab     <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_tmo     <= 1'b0;
      r_err_idx <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_tab     <= w_tab_n;
      r_idx     <= w_idx_n;
      r_err     <= w_err_n;
      r_tmo     <= w_tmo_n;
      r_err_idx <= w_err_idx_n;
      r_busy    <= is_busy(w_state_n);
      r_done    <= (w_state_n == S_DONE);
      r_wr_en   <= (w_state_n == S_WR_REQ);
      r_rd_en   <= (w_state_n == S_RD_REQ);
      r_addr    <= is_req(w_state_n) ? DATA_WIDTH'(w_idx_n) : '0;
      r_wdata   <= (w_state_n == S_WR_REQ) ? DATA_WIDTH'(w_entry_n) : '0;
    end
  end

  assign addr_o        = r_addr;
  assign wr_data_o     = r_wdata;
  assign wr_en_o       = r_wr_en;
  assign rd_en_o       = r_rd_en;
  assign valid_o       = w_valid;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign err_timeout_o = r_tmo;
  assign err_idx_o     = r_err_idx;

endmodule

// File: tb/tb_intc_prio_loader.sv
// Directed bench: two loaders (VERIFY=1 and VERIFY=0), each with a
// configurable register-port model (wait states, stall, read corruption).
module tb_intc_prio_loader;

  localparam logic [63:0] TAB_A = 64'h0123456789ABCDEF; // entry i = 15-i
  localparam logic [63:0] TAB_D = 64'hFEDCBA9876543210; // entry i = i

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   edge_cnt = 0;
  int   t0 = 0;
  int   tests = 0;
  int   fails = 0;

  logic        start [2];
  logic [63:0] tab [2];
  int          cfg_wait [2];
  int          cfg_stall [2];
  logic [15:0] cfg_corrupt [2];
  logic        clr [2];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  for (genvar g = 0; g < 2; g++) begin : gd
    logic        valid, wr_en, rd_en, busy, done, err, err_tmo;
    logic [15:0] addr, wdata;
    logic [3:0]  err_idx;
    logic        ready = 1'b0;
    logic [15:0] rdata = '0;
    logic [15:0] mem [16];
    int          vcnt = 0;
    int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic        rd_seen = 1'b0, seen4 = 1'b0, both = 1'b0;
    logic [15:0] wr_a [32];
    logic [15:0] wr_d [32];
    logic [15:0] rd_a [32];

    intc_prio_loader #(
      .DATA_WIDTH(16), .INTR_WIDTH(16), .INTR_ADDR(4),
      .VERIFY(g == 0), .TIMEOUT(15)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start[g]), .prio_table_i(tab[g]),
      .addr_o(addr), .wr_data_o(wdata), .wr_en_o(wr_en), .rd_en_o(rd_en),
      .valid_o(valid), .ready_i(ready), .rd_data_i(rdata), .busy_o(busy),
      .done_o(done), .err_o(err), .err_timeout_o(err_tmo), .err_idx_o(err_idx)
    );

    // Controller model: registered ready after cfg_wait extra cycles.
    always @(posedge clk) begin
      if (valid && ready && wr_en) mem[addr[3:0]] <= wdata;
      if (!valid || ready) vcnt <= 0;
      else vcnt <= vcnt + 1;
      if (valid && !ready && vcnt == cfg_wait[g] &&
          !(wr_en && int'(addr) == cfg_stall[g])) begin
        ready <= 1'b1;
        if (cfg_corrupt[g][addr[3:0]]) rdata <= (addr[3:0] == 4'd5) ? 16'h0000 : 16'h00FF;
        else rdata <= mem[addr[3:0]];
      end else begin
        ready <= 1'b0;
      end
    end

    // Transaction monitor, sampled mid-cycle.
    always @(negedge clk) begin
      if (clr[g]) begin
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_cyc = 0;
        rd_seen = 1'b0; seen4 = 1'b0; both = 1'b0;
      end
      if (valid && ready && wr_en) begin
        if (wr_cnt < 32) begin wr_a[wr_cnt] = addr; wr_d[wr_cnt] = wdata; end
        wr_cnt++;
      end
      if (valid && ready && rd_en) begin
        if (rd_cnt < 32) rd_a[rd_cnt] = addr;
        rd_cnt++;
      end
      if (done) begin done_cnt++; done_cyc = edge_cnt - t0 + 1; end
      if (rd_en) rd_seen = 1'b1;
      if (wr_en && rd_en) both = 1'b1;
      if (valid && addr == 16'd4) seen4 = 1'b1;
    end
  end

  function automatic logic [3:0] ent(input logic [63:0] t, input int i);
    return t[i*4 +: 4];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to mid-cycle c of the current run (cycle 1 follows the start edge).
  task automatic goto(input int c);
    while (edge_cnt - t0 + 1 < c) begin @(negedge clk); #1; end
  endtask

  // Pulse start for instance g; returns in cycle 1 of the new run.
  task automatic kick(input int g, input logic [63:0] t);
    clr[g] = 1'b1; start[g] = 1'b1; tab[g] = t;
    @(negedge clk); #1;
    clr[g] = 1'b0; start[g] = 1'b0;
    t0 = edge_cnt;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; tab[g] = '0; cfg_wait[g] = 0; cfg_stall[g] = -1;
      cfg_corrupt[g] = '0; clr[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", gd[0].valid, 0);
    chk("rst_busy",  gd[0].busy, 0);
    chk("rst_done",  gd[0].done, 0);
    chk("rst_err",   {gd[0].err, gd[0].err_tmo, gd[0].err_idx}, 0);
    chk("rst_addr",  gd[0].addr, 0);
    chk("rst_nv_outs", {gd[1].valid, gd[1].busy, gd[1].wr_en, gd[1].rd_en}, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Clean run, zero-wait, verify enabled
    kick(0, TAB_A);
    chk("c1_valid", gd[0].valid, 1);
    chk("c1_wr_en", gd[0].wr_en, 1);
    chk("c1_addr",  gd[0].addr, 0);
    chk("c1_wdata", gd[0].wdata, 16'd15);
    chk("c1_busy",  gd[0].busy, 1);
    goto(96);
    chk("c96_busy", gd[0].busy, 1);
    chk("c96_done", gd[0].done, 0);
    goto(97);
    chk("c97_done", gd[0].done, 1);
    chk("c97_busy", gd[0].busy, 0);
    goto(100);
    chk("A_wr_cnt", gd[0].wr_cnt, 16);
    chk("A_rd_cnt", gd[0].rd_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      chk("A_wr_addr", gd[0].wr_a[i], i);
      chk("A_wr_data", gd[0].wr_d[i], 15 - i);
      chk("A_rd_addr", gd[0].rd_a[i], i);
    end
    chk("A_done_cnt", gd[0].done_cnt, 1);
    chk("A_done_cyc", gd[0].done_cyc, 97);
    chk("A_err", gd[0].err, 0);
    chk("A_both_en", gd[0].both, 0);

    // Read-back corruption on entries 5 and 9
    cfg_corrupt[0] = 16'h0220;
    kick(0, TAB_A);
    goto(100);
    cfg_corrupt[0] = '0;
    chk("B_err", gd[0].err, 1);
    chk("B_err_idx", gd[0].err_idx, 5);
    chk("B_err_tmo", gd[0].err_tmo, 0);
    chk("B_rd_cnt", gd[0].rd_cnt, 16);
    chk("B_done_cyc", gd[0].done_cyc, 97);

    // Controller never acknowledges write 3
    cfg_stall[0] = 3;
    kick(0, TAB_A);
    chk("C_err_clr", gd[0].err, 0);
    goto(24);
    chk("C_c24_valid", gd[0].valid, 1);
    chk("C_c24_addr", gd[0].addr, 3);
    goto(25);
    chk("C_c25_valid", gd[0].valid, 0);
    chk("C_c25_done", gd[0].done, 1);
    chk("C_err", gd[0].err, 1);
    chk("C_err_tmo", gd[0].err_tmo, 1);
    chk("C_err_idx", gd[0].err_idx, 3);
    goto(30);
    cfg_stall[0] = -1;
    chk("C_no_entry4", gd[0].seen4, 0);
    chk("C_wr_cnt", gd[0].wr_cnt, 3);
    chk("C_done_cnt", gd[0].done_cnt, 1);

    // Table changes and a second start while busy
    kick(0, TAB_D);
    goto(2);
    tab[0] = 64'h3333333333333333;
    goto(20);
    start[0] = 1'b1;
    goto(21);
    start[0] = 1'b0;
    goto(100);
    for (int i = 0; i < 16; i++) chk("D_wr_data", gd[0].wr_d[i], ent(TAB_D, i));
    chk("D_done_cnt", gd[0].done_cnt, 1);
    chk("D_done_cyc", gd[0].done_cyc, 97);
    chk("D_err", gd[0].err, 0);

    // Reset in the middle of the write phase
    kick(0, TAB_A);
    goto(31);
    rst_n = 1'b0;
    goto(32);
    chk("E_outs", {gd[0].valid, gd[0].wr_en, gd[0].rd_en, gd[0].busy, gd[0].done}, 0);
    chk("E_addr", gd[0].addr, 0);
    chk("E_wdata", gd[0].wdata, 0);
    rst_n = 1'b1;
    goto(40);
    chk("E_no_done", gd[0].done_cnt, 0);
    chk("E_idle", gd[0].busy, 0);
    kick(0, TAB_A);
    goto(100);
    chk("E2_done_cnt", gd[0].done_cnt, 1);
    chk("E2_done_cyc", gd[0].done_cyc, 97);
    chk("E2_wr_cnt", gd[0].wr_cnt, 16);
    chk("E2_err", gd[0].err, 0);

    // Write-only loader, two wait states per access
    cfg_wait[1] = 2;
    kick(1, TAB_A);
    goto(85);
    chk("F_wr_cnt", gd[1].wr_cnt, 16);
    for (int i = 0; i < 16; i++) chk("F_wr_data", gd[1].wr_d[i], 15 - i);
    chk("F_rd_seen", gd[1].rd_seen, 0);
    chk("F_done_cnt", gd[1].done_cnt, 1);
    chk("F_done_cyc", gd[1].done_cyc, 81);
    chk("F_err", gd[1].err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
